// File: rtl/rambus_pkg.sv
// Shared types and constants for the rambus shared-RAM controller.
package rambus_pkg;

  localparam int RAMBUS_ADDR_W = 8;
  localparam int RAMBUS_DATA_W = 32;

  localparam int M0 = 0;
  localparam int M1 = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2,
    ACK  = 2'd3
  } rambus_state_e;

endpackage

// File: rtl/rambus_rr_arbiter.sv
// Two-request round-robin arbiter; the pointer names the master that wins a tie.
module rambus_rr_arbiter
  import rambus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q;

  always_comb begin
    grant = 2'b00;
    if (req[M0] && req[M1]) begin
      grant[ptr_q] = 1'b1;
    end else if (req[M0]) begin
      grant[M0] = 1'b1;
    end else if (req[M1]) begin
      grant[M1] = 1'b1;
    end
  end

  // After any grant the master that was not served is favoured next.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (advance && (|grant)) begin
      ptr_q <= grant[M0];
    end
  end

endmodule

// File: rtl/rambus_ram_controller.sv
// Two-master Wishbone front end for a single-port 256x32 OpenRAM macro with fixed access latency.
// Build option RAMBUS_M0_WRITE_PROTECT_EN makes m0 read-only and adds the sticky m0_wr_err_o flag.
module rambus_ram_controller
  import rambus_pkg::*;
#(
  parameter int ADDR_W = RAMBUS_ADDR_W,
  parameter int DATA_W = RAMBUS_DATA_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  // Handshake: a master requests while cyc&stb are high and holds the request until
  // its ack_o pulses for one cycle; dropping cyc before ACK abandons it with no ack.
  input  logic              m0_wb_cyc_i,
  input  logic              m0_wb_stb_i,
  input  logic              m0_wb_we_i,
  input  logic [3:0]        m0_wb_sel_i,
  input  logic [ADDR_W-1:0] m0_wb_adr_i,
  input  logic [DATA_W-1:0] m0_wb_dat_i,
  output logic              m0_wb_ack_o,
  output logic [DATA_W-1:0] m0_wb_dat_o,
  input  logic              m1_wb_cyc_i,
  input  logic              m1_wb_stb_i,
  input  logic              m1_wb_we_i,
  input  logic [3:0]        m1_wb_sel_i,
  input  logic [ADDR_W-1:0] m1_wb_adr_i,
  input  logic [DATA_W-1:0] m1_wb_dat_i,
  output logic              m1_wb_ack_o,
  output logic [DATA_W-1:0] m1_wb_dat_o,
  output logic              ram_csb0_o,
  output logic              ram_web0_o,
  output logic [3:0]        ram_wmask0_o,
  output logic [ADDR_W-1:0] ram_addr0_o,
  output logic [DATA_W-1:0] ram_din0_o,
  input  logic [DATA_W-1:0] ram_dout0_i,
`ifdef RAMBUS_M0_WRITE_PROTECT_EN
  output logic              m0_wr_err_o,
`endif
  output logic [1:0]        state_dbg_o
);

  rambus_state_e     state_q, state_d;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic              start;
  logic              gnt_q;
  logic              we_q;
  logic              abort_q;
  logic              gnt_cyc;
  logic              blocked;
  logic              we_w;
  logic [3:0]        sel_w;
  logic [ADDR_W-1:0] adr_w;
  logic [DATA_W-1:0] dat_w;
  logic [DATA_W-1:0] rdata_q;

  assign req = {m1_wb_cyc_i & m1_wb_stb_i, m0_wb_cyc_i & m0_wb_stb_i};

  rambus_rr_arbiter u_arb (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .req     (req),
    .advance (start),
    .grant   (grant)
  );

  assign we_w    = grant[M1] ? m1_wb_we_i  : m0_wb_we_i;
  assign sel_w   = grant[M1] ? m1_wb_sel_i : m0_wb_sel_i;
  assign adr_w   = grant[M1] ? m1_wb_adr_i : m0_wb_adr_i;
  assign dat_w   = grant[M1] ? m1_wb_dat_i : m0_wb_dat_i;
  assign gnt_cyc = gnt_q ? m1_wb_cyc_i : m0_wb_cyc_i;

`ifdef RAMBUS_M0_WRITE_PROTECT_EN
  // A protected m0 write runs the full sequence but never selects the macro.
  assign blocked = grant[M0] & m0_wb_we_i;
`else
  assign blocked = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          start   = 1'b1;
          state_d = CMD;
        end
      end
      CMD:  state_d = RESP;
      RESP: state_d = (abort_q || !gnt_cyc) ? IDLE : ACK;
      ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      abort_q      <= 1'b0;
      rdata_q      <= '0;
      ram_csb0_o   <= 1'b1;
      ram_web0_o   <= 1'b1;
      ram_wmask0_o <= 4'h0;
      ram_addr0_o  <= '0;
      ram_din0_o   <= '0;
    end else begin
      if (start) begin
        gnt_q        <= grant[M1];
        we_q         <= we_w;
        abort_q      <= 1'b0;
        ram_csb0_o   <= blocked;
        ram_web0_o   <= ~we_w | blocked;
        ram_wmask0_o <= (we_w && !blocked) ? sel_w : 4'h0;
        ram_addr0_o  <= adr_w;
        ram_din0_o   <= dat_w;
      end
      // The macro samples at the end of CMD; the access completes even if cyc drops.
      if (state_q == CMD) begin
        ram_csb0_o <= 1'b1;
        ram_web0_o <= 1'b1;
        if (!gnt_cyc) begin
          abort_q <= 1'b1;
        end
      end
      if ((state_q == RESP) && !we_q) begin
        rdata_q <= ram_dout0_i;
      end
    end
  end

`ifdef RAMBUS_M0_WRITE_PROTECT_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      m0_wr_err_o <= 1'b0;
    end else if (start && blocked) begin
      m0_wr_err_o <= 1'b1;
    end
  end
`endif

  assign m0_wb_ack_o = (state_q == ACK) && !gnt_q;
  assign m1_wb_ack_o = (state_q == ACK) && gnt_q;
  assign m0_wb_dat_o = rdata_q;
  assign m1_wb_dat_o = rdata_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_rambus_ram_controller.sv
// Bench for rambus_ram_controller: directed scenarios plus random traffic against a transaction-level model.
module tb_rambus_ram_controller;
  import rambus_pkg::*;

`ifdef RAMBUS_M0_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  cyc, stb, we;
  logic [3:0]  sel  [2];
  logic [7:0]  adr  [2];
  logic [31:0] wdat [2];
  logic        ack0, ack1;
  logic [31:0] rdat0, rdat1;
  logic        ram_csb0, ram_web0;
  logic [3:0]  ram_wmask0;
  logic [7:0]  ram_addr0;
  logic [31:0] ram_din0, ram_dout;
  logic [1:0]  state_dbg;
  logic        wr_err;

  rambus_ram_controller dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_wb_cyc_i(cyc[0]), .m0_wb_stb_i(stb[0]), .m0_wb_we_i(we[0]), .m0_wb_sel_i(sel[0]),
    .m0_wb_adr_i(adr[0]), .m0_wb_dat_i(wdat[0]), .m0_wb_ack_o(ack0), .m0_wb_dat_o(rdat0),
    .m1_wb_cyc_i(cyc[1]), .m1_wb_stb_i(stb[1]), .m1_wb_we_i(we[1]), .m1_wb_sel_i(sel[1]),
    .m1_wb_adr_i(adr[1]), .m1_wb_dat_i(wdat[1]), .m1_wb_ack_o(ack1), .m1_wb_dat_o(rdat1),
    .ram_csb0_o(ram_csb0), .ram_web0_o(ram_web0), .ram_wmask0_o(ram_wmask0),
    .ram_addr0_o(ram_addr0), .ram_din0_o(ram_din0), .ram_dout0_i(ram_dout),
`ifdef RAMBUS_M0_WRITE_PROTECT_EN
    .m0_wr_err_o(wr_err),
`endif
    .state_dbg_o(state_dbg)
  );

`ifndef RAMBUS_M0_WRITE_PROTECT_EN
  assign wr_err = 1'b0;
`endif

  // Behavioural RAM macro: samples on the edge that ends the csb0-low cycle.
  logic        mem_clear;
  logic [31:0] ram_mem [256];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
      ram_dout <= '0;
    end else if (!ram_csb0) begin
      if (!ram_web0) begin
        for (int b = 0; b < 4; b++)
          if (ram_wmask0[b]) ram_mem[ram_addr0][b*8 +: 8] <= ram_din0[b*8 +: 8];
      end else begin
        ram_dout <= ram_mem[ram_addr0];
      end
    end
  end

  // Bus monitor counters and the RAM command seen in the most recent csb0-low cycle.
  int          csb_low_cnt = 0, ack0_cnt = 0, ack1_cnt = 0, both_ack_cnt = 0;
  logic [3:0]  cap_wmask;
  logic [7:0]  cap_addr;
  logic [31:0] cap_din;
  logic        cap_web;
  always @(negedge clk) begin
    if (!ram_csb0) begin
      csb_low_cnt++;
      cap_wmask = ram_wmask0;
      cap_addr  = ram_addr0;
      cap_din   = ram_din0;
      cap_web   = ram_web0;
    end
    if (ack0) ack0_cnt++;
    if (ack1) ack1_cnt++;
    if (ack0 && ack1) both_ack_cnt++;
  end

  // Transaction-level reference: memory image, tie-break pointer, last read data, error flag.
  logic [31:0] ref_mem [256];
  int          model_ptr;
  logic [31:0] last_rd;
  logic        exp_err;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic model_op(input int m, input logic w, input logic [3:0] s, input logic [7:0] a,
                          input logic [31:0] d, output logic [31:0] exp_rd, output int exp_csb);
    exp_csb = 1;
    if (!w) begin
      last_rd = ref_mem[a];
    end else if (PROT && m == 0) begin
      exp_csb = 0;
      exp_err = 1'b1;
    end else begin
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
    end
    exp_rd = last_rd;
    model_ptr = 1 - m;
  endtask

  // driver: one Wishbone transfer; cycles counts negedges from request to the ack cycle
  task automatic bus_access(input int m, input logic w, input logic [3:0] s, input logic [31:0] a,
                            input logic [31:0] d, output logic [31:0] rd, output int cycles,
                            output bit timed_out);
    cyc[m] = 1'b1; stb[m] = 1'b1; we[m] = w; sel[m] = s; adr[m] = a[7:0]; wdat[m] = d;
    cycles = 0; timed_out = 1'b1; rd = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cycles++;
      if ((m == 0 && ack0) || (m == 1 && ack1)) begin
        rd = (m == 0) ? rdat0 : rdat1;
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    cyc[m] = 1'b0; stb[m] = 1'b0; we[m] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_ptr = 0; last_rd = '0; exp_err = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 mem_clear = 1'b0;
    @(negedge clk);
    n_checks++; if (ram_csb0 !== 1'b1) begin n_fail++; $display("FAIL reset_csb0: got %b expected 1", ram_csb0); end
    n_checks++; if (ram_web0 !== 1'b1) begin n_fail++; $display("FAIL reset_web0: got %b expected 1", ram_web0); end
    n_checks++; if ({ram_wmask0, ram_addr0, ram_din0} !== 44'h0) begin n_fail++; $display("FAIL reset_ram_bus: got %h/%h/%h expected 0", ram_wmask0, ram_addr0, ram_din0); end
    n_checks++; if ({ack0, ack1} !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b expected 00", {ack0, ack1}); end
    n_checks++; if ({rdat0, rdat1} !== 64'h0) begin n_fail++; $display("FAIL reset_dat: got %h %h expected 0", rdat0, rdat1); end
    n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err: got %b expected 0", wr_err); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", state_dbg); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd, e; int n, ec, c; bit to;
    c = csb_low_cnt;
    model_op(1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, e, ec);
    bus_access(1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, n, to);
    n_checks++; if (to || n != 4) begin n_fail++; $display("FAIL wr_latency: got %0d cycles (timeout %b) expected 4", n, to); end
    n_checks++; if (csb_low_cnt - c != 1) begin n_fail++; $display("FAIL wr_csb_low: got %0d cycles expected 1", csb_low_cnt - c); end
    n_checks++; if ({cap_web, cap_wmask, cap_addr, cap_din} !== {1'b0, 4'hF, 8'h10, 32'hDEADBEEF}) begin n_fail++; $display("FAIL wr_ram_cmd: got web=%b mask=%h addr=%h din=%h expected 0/f/10/deadbeef", cap_web, cap_wmask, cap_addr, cap_din); end
    n_checks++; if (rd !== e) begin n_fail++; $display("FAIL wr_dat_held: got %h expected %h", rd, e); end
    c = csb_low_cnt;
    model_op(0, 1'b0, 4'h0, 8'h10, 32'h0, e, ec);
    bus_access(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, n, to);
    n_checks++; if (to || n != 4) begin n_fail++; $display("FAIL rd_latency: got %0d cycles (timeout %b) expected 4", n, to); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    n_checks++; if (csb_low_cnt - c != 1 || cap_web !== 1'b1 || cap_wmask !== 4'h0) begin n_fail++; $display("FAIL rd_ram_cmd: got csb_low=%0d web=%b mask=%h expected 1/1/0", csb_low_cnt - c, cap_web, cap_wmask); end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd, e; int n, ec, a0c; bit to;
    a0c = ack0_cnt;
    model_op(1, 1'b1, 4'hF, 8'h30, 32'h11223344, e, ec);
    bus_access(1, 1'b1, 4'hF, 32'h30, 32'h11223344, rd, n, to);
    model_op(1, 1'b1, 4'h1, 8'h30, 32'h000000AA, e, ec);
    bus_access(1, 1'b1, 4'h1, 32'h30, 32'h000000AA, rd, n, to);
    n_checks++; if (cap_wmask !== 4'h1) begin n_fail++; $display("FAIL byte_wmask: got %h expected 1", cap_wmask); end
    n_checks++; if (ack0_cnt != a0c) begin n_fail++; $display("FAIL byte_other_ack: got %0d m0 acks expected 0", ack0_cnt - a0c); end
    model_op(0, 1'b0, 4'hF, 8'h30, 32'h0, e, ec);
    bus_access(0, 1'b0, 4'hF, 32'h30, 32'h0, rd, n, to);
    n_checks++; if (rd !== 32'h112233AA) begin n_fail++; $display("FAIL byte_readback: got %h expected 112233aa", rd); end
  endtask

  task automatic test_arbitration();
    logic [31:0] rd_a, rd_b, rd_c, e_a, e_b, e_c; int n_a, n_b, n_c, ec, both; bit to_a, to_b, to_c;
    do_reset();
    both = both_ack_cnt;
    model_op(0, 1'b0, 4'h0, 8'h10, 32'h0, e_a, ec);
    model_op(1, 1'b1, 4'hF, 8'h40, 32'h0BADF00D, e_c, ec);
    model_op(0, 1'b0, 4'h0, 8'h30, 32'h0, e_b, ec);
    fork
      begin
        bus_access(0, 1'b0, 4'h0, 32'h10, 32'h0, rd_a, n_a, to_a);
        bus_access(0, 1'b0, 4'h0, 32'h30, 32'h0, rd_b, n_b, to_b);
      end
      bus_access(1, 1'b1, 4'hF, 32'h40, 32'h0BADF00D, rd_c, n_c, to_c);
    join
    n_checks++; if (to_a || n_a != 4) begin n_fail++; $display("FAIL arb_first_m0: got %0d cycles expected 4", n_a); end
    n_checks++; if (to_c || n_c != 8) begin n_fail++; $display("FAIL arb_then_m1: got %0d cycles expected 8", n_c); end
    n_checks++; if (to_b || n_b != 8) begin n_fail++; $display("FAIL arb_second_pair_m1_first: got m0 %0d cycles expected 8", n_b); end
    n_checks++; if (rd_a !== e_a || rd_b !== e_b || rd_c !== e_c) begin n_fail++; $display("FAIL arb_data: got %h %h %h expected %h %h %h", rd_a, rd_b, rd_c, e_a, e_b, e_c); end
    n_checks++; if (both_ack_cnt != both) begin n_fail++; $display("FAIL arb_dual_ack: got %0d expected 0", both_ack_cnt - both); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd, e; int n, ec; bit to;
    model_op(1, 1'b1, 4'hF, 8'h05, 32'hCAFEF00D, e, ec);
    bus_access(1, 1'b1, 4'hF, 32'hFFFF_FF05, 32'hCAFEF00D, rd, n, to);
    model_op(0, 1'b0, 4'h0, 8'h05, 32'h0, e, ec);
    bus_access(0, 1'b0, 4'h0, 32'h0000_0105, 32'h0, rd, n, to);
    n_checks++; if (cap_addr !== 8'h05) begin n_fail++; $display("FAIL wrap_addr: got %h expected 05", cap_addr); end
    n_checks++; if (rd !== e) begin n_fail++; $display("FAIL wrap_data: got %h expected %h", rd, e); end
  endtask

  task automatic test_abort();
    logic [31:0] rd, e; int n, ec, a0c, a1c; bit to;
    a0c = ack0_cnt; a1c = ack1_cnt;
    model_op(0, 1'b0, 4'h0, 8'h10, 32'h0, e, ec);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 8'h10;
    @(posedge clk); @(posedge clk); #1;
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (state_dbg !== RESP) begin n_fail++; $display("FAIL abort_in_resp: got state %0d expected RESP", state_dbg); end
    @(negedge clk);
    n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL abort_resp_idle: got state %0d expected IDLE", state_dbg); end
    model_op(1, 1'b1, 4'hF, 8'h50, 32'h77665544, e, ec);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; adr[1] = 8'h50; wdat[1] = 32'h77665544;
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL abort_cmd_idle: got state %0d expected IDLE", state_dbg); end
    repeat (3) @(negedge clk);
    n_checks++; if (ack0_cnt != a0c || ack1_cnt != a1c) begin n_fail++; $display("FAIL abort_no_ack: got %0d/%0d acks expected 0/0", ack0_cnt - a0c, ack1_cnt - a1c); end
    @(posedge clk); #1;
    model_op(0, 1'b0, 4'h0, 8'h50, 32'h0, e, ec);
    bus_access(0, 1'b0, 4'h0, 32'h50, 32'h0, rd, n, to);
    n_checks++; if (to || rd !== 32'h77665544) begin n_fail++; $display("FAIL abort_write_committed: got %h expected 77665544", rd); end
  endtask

  task automatic test_m0_write();
    logic [31:0] rd, e; int n, ec, c; bit to;
    model_op(1, 1'b1, 4'hF, 8'h20, 32'h99887766, e, ec);
    bus_access(1, 1'b1, 4'hF, 32'h20, 32'h99887766, rd, n, to);
    c = csb_low_cnt;
    model_op(0, 1'b1, 4'hF, 8'h20, 32'h00000055, e, ec);
    bus_access(0, 1'b1, 4'hF, 32'h20, 32'h00000055, rd, n, to);
    n_checks++; if (to || n != 4) begin n_fail++; $display("FAIL m0_write_ack: got %0d cycles (timeout %b) expected 4", n, to); end
    n_checks++; if (csb_low_cnt - c != ec) begin n_fail++; $display("FAIL m0_write_csb: got %0d low cycles expected %0d", csb_low_cnt - c, ec); end
    n_checks++; if (wr_err !== exp_err) begin n_fail++; $display("FAIL m0_write_err: got %b expected %b", wr_err, exp_err); end
    model_op(1, 1'b0, 4'h0, 8'h20, 32'h0, e, ec);
    bus_access(1, 1'b0, 4'h0, 32'h20, 32'h0, rd, n, to);
    n_checks++; if (rd !== e) begin n_fail++; $display("FAIL m0_write_readback: got %h expected %h", rd, e); end
    do_reset();
    @(negedge clk);
    n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL m0_write_err_clear: got %b expected 0", wr_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] rd0, rd1, e0, e1, d0, d1; int n0, n1, ec0, ec1, c, mode, win, both; bit to0, to1;
    logic w0, w1; logic [3:0] s0, s1; logic [7:0] a0, a1;
    both = both_ack_cnt;
    for (int it = 0; it < 40; it++) begin
      w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      s0 = 4'($urandom_range(0, 15)); s1 = 4'($urandom_range(0, 15));
      a0 = 8'($urandom_range(0, 7)); a1 = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a0 = 8'($urandom);
      d0 = $urandom; d1 = $urandom;
      mode = $urandom_range(0, 2);
      c = csb_low_cnt;
      if (mode < 2) begin
        model_op(mode, w0, s0, a0, d0, e0, ec0);
        bus_access(mode, w0, s0, {24'h0, a0}, d0, rd0, n0, to0);
        n_checks++; if (to0 || n0 != 4 || rd0 !== e0) begin n_fail++; $display("FAIL rand_single[%0d]: got m%0d %0d cycles data %h expected 4 cycles data %h", it, mode, n0, rd0, e0); end
        n_checks++; if (csb_low_cnt - c != ec0) begin n_fail++; $display("FAIL rand_single_csb[%0d]: got %0d expected %0d", it, csb_low_cnt - c, ec0); end
      end else begin
        win = model_ptr;
        if (win == 0) begin
          model_op(0, w0, s0, a0, d0, e0, ec0);
          model_op(1, w1, s1, a1, d1, e1, ec1);
        end else begin
          model_op(1, w1, s1, a1, d1, e1, ec1);
          model_op(0, w0, s0, a0, d0, e0, ec0);
        end
        fork
          bus_access(0, w0, s0, {24'h0, a0}, d0, rd0, n0, to0);
          bus_access(1, w1, s1, {24'h0, a1}, d1, rd1, n1, to1);
        join
        n_checks++; if (to0 || to1 || n0 != (win == 0 ? 4 : 8) || n1 != (win == 1 ? 4 : 8)) begin n_fail++; $display("FAIL rand_pair_order[%0d]: got m0 %0d m1 %0d cycles, winner should be m%0d", it, n0, n1, win); end
        n_checks++; if (rd0 !== e0 || rd1 !== e1) begin n_fail++; $display("FAIL rand_pair_data[%0d]: got %h %h expected %h %h", it, rd0, rd1, e0, e1); end
        n_checks++; if (csb_low_cnt - c != ec0 + ec1) begin n_fail++; $display("FAIL rand_pair_csb[%0d]: got %0d expected %0d", it, csb_low_cnt - c, ec0 + ec1); end
      end
      n_checks++; if (wr_err !== exp_err) begin n_fail++; $display("FAIL rand_wr_err[%0d]: got %b expected %b", it, wr_err, exp_err); end
    end
    n_checks++; if (both_ack_cnt != both) begin n_fail++; $display("FAIL rand_dual_ack: got %0d expected 0", both_ack_cnt - both); end
  endtask

  task automatic test_reset_mid_cmd();
    logic [31:0] rd, e; int n, ec, a0c, a1c; bit to;
    a0c = ack0_cnt; a1c = ack1_cnt;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; adr[1] = 8'h60; wdat[1] = 32'h12345678;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_checks++; if (state_dbg !== CMD || ram_csb0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_cmd_pre: got state %0d csb0 %b expected CMD/0", state_dbg, ram_csb0); end
    @(posedge clk); #1;
    rst = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    model_ptr = 0; last_rd = '0; exp_err = 1'b0;
    @(negedge clk);
    n_checks++; if (state_dbg !== IDLE || ram_csb0 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_cmd_post: got state %0d csb0 %b expected IDLE/1", state_dbg, ram_csb0); end
    repeat (4) @(negedge clk);
    n_checks++; if (ack0_cnt != a0c || ack1_cnt != a1c) begin n_fail++; $display("FAIL rst_mid_cmd_ack: got %0d/%0d acks expected 0/0", ack0_cnt - a0c, ack1_cnt - a1c); end
    @(posedge clk); #1;
    model_op(0, 1'b0, 4'h0, 8'h50, 32'h0, e, ec);
    bus_access(0, 1'b0, 4'h0, 32'h50, 32'h0, rd, n, to);
    n_checks++; if (to || n != 4 || rd !== e) begin n_fail++; $display("FAIL rst_recover: got %0d cycles data %h expected 4 cycles data %h", n, rd, e); end
  endtask

  initial begin
    rst = 1'b1; mem_clear = 1'b1;
    cyc = '0; stb = '0; we = '0;
    for (int m = 0; m < 2; m++) begin sel[m] = '0; adr[m] = '0; wdat[m] = '0; end
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    model_ptr = 0; last_rd = '0; exp_err = 1'b0;
    test_reset();
    test_write_read();
    test_byte_write();
    test_arbitration();
    test_wrap();
    test_abort();
    test_m0_write();
    test_random();
    test_reset_mid_cmd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
